// File: rtl/usb_rx_ctrl.sv
// Receive control FSM for the USB 1.1 RX path: sequences one packet per run from the
// first line edge through SYNC check, byte stores, EOP alignment check and error reporting.
module usb_rx_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic       packet_done,
  output logic [7:0] byte_cnt
);

  localparam logic [7:0] MaxCnt = 8'(MAX_BYTES);

  typedef enum logic [2:0] {
    StIdle, StErrIdle, StSyncRcv, StDataRcv, StStore, StEopWait, StErrEop, StErrWait
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] byte_cnt_q;
  logic       r_error_q;
  logic       start;
  logic       eop_bit;

  assign start   = ((state_q == StIdle) || (state_q == StErrIdle)) && d_edge;
  assign eop_bit = eop && shift_enable;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StErrIdle: begin
        if (d_edge) state_d = StSyncRcv;
      end
      StSyncRcv: begin
        if (byte_received) begin
          state_d = (rcv_data == SYNC_BYTE) ? StDataRcv : StErrEop;
        end else if (eop_bit) begin
          state_d = StErrEop;
        end
      end
      StDataRcv: begin
        // A completed byte wins over a coincident EOP; EOP is re-checked on the next bit.
        if (byte_received) begin
          state_d = (byte_cnt_q < MaxCnt) ? StStore : StErrEop;
        end else if (eop_bit) begin
          state_d = ((bit_cnt_q == 3'd0) && (byte_cnt_q != 8'd0)) ? StEopWait : StErrEop;
        end
      end
      StStore:   state_d = StDataRcv;
      StEopWait: if (!eop) state_d = StIdle;
      StErrEop:  if (eop_bit) state_d = StErrWait;
      StErrWait: if (!eop) state_d = StErrIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      r_error_q  <= 1'b0;
    end else begin
      if (start) begin
        bit_cnt_q <= 3'd0;
      end else if (shift_enable) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      if (start) begin
        byte_cnt_q <= 8'd0;
      end else if ((state_q == StStore) && (byte_cnt_q < MaxCnt)) begin
        byte_cnt_q <= byte_cnt_q + 8'd1;
      end

      if (start) begin
        r_error_q <= 1'b0;
      end else if ((state_d == StErrEop) && (state_q != StErrEop)) begin
        r_error_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rcving      = 1'b0;
    w_enable    = 1'b0;
    packet_done = 1'b0;
    case (state_q)
      StSyncRcv, StDataRcv, StErrEop, StErrWait: rcving = 1'b1;
      StStore: begin
        rcving   = 1'b1;
        w_enable = 1'b1;
      end
      StEopWait: begin
        rcving      = 1'b1;
        packet_done = !eop;
      end
      default: ;
    endcase
  end

  assign r_error  = r_error_q;
  assign byte_cnt = byte_cnt_q;

endmodule
